// File: rtl/collatz_sweep.sv
// Sweeps a range of seeds through an external Collatz core and keeps the longest orbit seen.
// Each nonzero seed costs LAUNCH, ARM, WAIT (held while the core is busy) and UPDATE; a zero seed is skipped in one cycle.
module collatz_sweep #(
   parameter int SEED_BITS = 64,
   parameter int OLEN_BITS = 16,
   parameter int PLEN_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_we,
   input  logic [3:0]           cfg_addr,
   input  logic [7:0]           cfg_data,
   input  logic                 go,
   input  logic                 abort,
   output logic                 core_start,
   output logic [SEED_BITS-1:0] core_seed,
   input  logic                 core_busy,
   input  logic [OLEN_BITS-1:0] core_orbit_len,
   input  logic [PLEN_BITS-1:0] core_path_record,
   output logic                 running,
   output logic                 done,
   output logic [OLEN_BITS-1:0] best_len,
   output logic [SEED_BITS-1:0] best_seed,
   output logic [PLEN_BITS-1:0] best_path,
   output logic [15:0]          seeds_done
);

   localparam int SEED_BYTES = (SEED_BITS / 8 > 8) ? 8 : SEED_BITS / 8;

   typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT, UPDATE, DONE} state_t;

   state_t               state;
   logic [SEED_BITS-1:0] start_seed;
   logic [SEED_BITS-1:0] cur_seed;
   logic [15:0]          count;
   logic [15:0]          remaining;
   logic [OLEN_BITS-1:0] cap_len;
   logic [PLEN_BITS-1:0] cap_path;
   logic                 start_q;
   logic [SEED_BITS-1:0] seed_inc;
   logic [15:0]          rem_dec;

   assign seed_inc = cur_seed + SEED_BITS'(1);
   assign rem_dec  = remaining - 16'd1;
   assign running  = (state == LAUNCH) || (state == ARM) || (state == WAIT) || (state == UPDATE);
   assign done     = (state == DONE);

   // The launch pulse is registered on entry to LAUNCH; abort in that same cycle must still suppress it.
   assign core_start = start_q & ~abort;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         start_seed <= '0;
         count      <= '0;
         cur_seed   <= '0;
         remaining  <= '0;
         best_len   <= '0;
         best_seed  <= '0;
         best_path  <= '0;
         seeds_done <= '0;
         cap_len    <= '0;
         cap_path   <= '0;
         start_q    <= 1'b0;
         core_seed  <= '0;
      end else begin
         start_q <= 1'b0;
         if (abort && running) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (cfg_we) begin
                     for (int i = 0; i < SEED_BYTES; i++) begin
                        if (cfg_addr == 4'(i)) start_seed[8*i +: 8] <= cfg_data;
                     end
                     if (cfg_addr == 4'd8) count[7:0]  <= cfg_data;
                     if (cfg_addr == 4'd9) count[15:8] <= cfg_data;
                     state <= IDLE;
                  end else if (go) begin
                     best_len   <= '0;
                     best_seed  <= '0;
                     best_path  <= '0;
                     seeds_done <= '0;
                     cur_seed   <= start_seed;
                     remaining  <= count;
                     core_seed  <= start_seed;
                     if (count == 16'd0) begin
                        state <= DONE;
                     end else begin
                        state   <= LAUNCH;
                        start_q <= (start_seed != '0);
                     end
                  end
               end
               LAUNCH: begin
                  if (cur_seed != '0) begin
                     state <= ARM;
                  end else begin
                     seeds_done <= seeds_done + 16'd1;
                     remaining  <= rem_dec;
                     cur_seed   <= seed_inc;
                     core_seed  <= seed_inc;
                     if (rem_dec == 16'd0) begin
                        state <= DONE;
                     end else begin
                        start_q <= (seed_inc != '0);
                     end
                  end
               end
               ARM: begin
                  state <= WAIT;
               end
               WAIT: begin
                  if (!core_busy) begin
                     cap_len  <= core_orbit_len;
                     cap_path <= core_path_record;
                     state    <= UPDATE;
                  end
               end
               UPDATE: begin
                  // Strict compare so an equal-length later seed never displaces the earlier one.
                  if (cap_len > best_len) begin
                     best_len  <= cap_len;
                     best_seed <= cur_seed;
                     best_path <= cap_path;
                  end
                  seeds_done <= seeds_done + 16'd1;
                  remaining  <= rem_dec;
                  cur_seed   <= seed_inc;
                  core_seed  <= seed_inc;
                  if (rem_dec == 16'd0) begin
                     state <= DONE;
                  end else begin
                     state   <= LAUNCH;
                     start_q <= (seed_inc != '0);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_collatz_sweep.sv
// Bench for collatz_sweep: a behavioural Collatz core plus table, hand-written and randomized sweep checks.
module tb_collatz_sweep;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic        go;
   logic        abort;
   logic        core_start;
   logic [63:0] core_seed;
   logic        core_busy;
   logic [15:0] core_orbit_len;
   logic [15:0] core_path_record;
   logic        running;
   logic        done;
   logic [15:0] best_len;
   logic [63:0] best_seed;
   logic [15:0] best_path;
   logic [15:0] seeds_done;

   int n_checks = 0;
   int n_fail   = 0;
   int starts   = 0;
   int busy_cnt = 0;

   collatz_sweep #(.SEED_BITS(64), .OLEN_BITS(16), .PLEN_BITS(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .go(go), .abort(abort), .core_start(core_start), .core_seed(core_seed),
      .core_busy(core_busy), .core_orbit_len(core_orbit_len), .core_path_record(core_path_record),
      .running(running), .done(done), .best_len(best_len), .best_seed(best_seed),
      .best_path(best_path), .seeds_done(seeds_done)
   );

   always #5 clk = ~clk;

   // Standard step count to reach 1; path record is the orbit peak (low 16 bits).
   function automatic void ref_orbit(input logic [63:0] s, output int len, output logic [15:0] path);
      logic [191:0] v;
      logic [191:0] peak;
      v = 192'(s);
      peak = v;
      len = 0;
      while (v != 192'd1 && len < 1000) begin
         if (v[0]) v = v * 192'd3 + 192'd1;
         else v = v >> 1;
         len++;
         if (v > peak) peak = v;
      end
      path = peak[15:0];
   endfunction

   always @(posedge clk) begin : core_model
      int l;
      logic [15:0] p;
      if (core_start) begin
         ref_orbit(core_seed, l, p);
         busy_cnt         <= l + 1;
         core_orbit_len   <= 16'(l);
         core_path_record <= p;
         starts           <= starts + 1;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end
   assign core_busy = (busy_cnt != 0);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Sweep result model: walk the seed range with plain arithmetic.
   task automatic model(input logic [63:0] seed, input int cnt, output logic [63:0] bs,
                        output int bl, output logic [15:0] bp, output int ns);
      logic [63:0] s;
      int l;
      logic [15:0] p;
      s = seed; bs = 0; bl = 0; bp = 0; ns = 0;
      for (int k = 0; k < cnt; k++) begin
         if (s != 0) begin
            ref_orbit(s, l, p);
            ns++;
            if (l > bl) begin bl = l; bs = s; bp = p; end
         end
         s = s + 64'd1;
      end
   endtask

   task automatic write_cfg(input logic [63:0] seed, input logic [15:0] cnt);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cfg_we   = 1'b1;
         cfg_addr = 4'(i);
         cfg_data = (i < 8) ? seed[8*i +: 8] : cnt[8*(i-8) +: 8];
      end
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic go_and_wait(input bit poke, output int cyc, output int nst);
      int s0;
      s0 = starts;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go  = 1'b0;
      cyc = 0;
      if (poke) begin
         go = 1'b1;
         @(negedge clk);
         go       = 1'b0;
         cfg_we   = 1'b1;
         cfg_addr = 4'd8;
         cfg_data = 8'($urandom_range(1, 255));
         @(negedge clk);
         cfg_we = 1'b0;
         cyc    = 2;
      end
      while (!done && cyc < 30000) begin
         @(negedge clk);
         cyc++;
      end
      check("sweep_reaches_done", done, 1);
      nst = starts - s0;
   endtask

   typedef struct {
      logic [63:0] seed;
      int          cnt;
      logic [63:0] exp_seed;
      int          exp_len;   // -1: take from the reference model
      int          exp_sd;
      int          exp_starts;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int          cyc, nst, ml, ns, s0;
      logic [63:0] ms;
      logic [15:0] mp;
      int          el;
      logic [15:0] ep;

      vecs[0] = '{64'd1, 10, 64'd9, 19, 10, 10};
      vecs[1] = '{64'd12, 2, 64'd12, 9, 2, 2};
      vecs[2] = '{64'd0, 3, 64'd2, 1, 3, 2};
      vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 64'hFFFF_FFFF_FFFF_FFFF, -1, 2, 1};
      vecs[4] = '{64'd27, 1, 64'd27, 111, 1, 1};
      vecs[5] = '{64'd5, 0, 64'd0, 0, 0, 0};

      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; go = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_running", running, 0);
      check("rst_done", done, 0);
      check("rst_core_start", core_start, 0);
      check("rst_core_seed", core_seed, 0);
      check("rst_best_len", best_len, 0);
      check("rst_seeds_done", seeds_done, 0);
      rst_n = 1'b1;

      // Reset leaves count at 0, so a bare go finishes immediately.
      go_and_wait(1'b0, cyc, nst);
      check("rst_count_zero_cycles", (cyc <= 2), 1);
      check("rst_count_zero_sd", seeds_done, 0);

      for (int v = 0; v < 6; v++) begin
         write_cfg(vecs[v].seed, 16'(vecs[v].cnt));
         go_and_wait(1'b0, cyc, nst);
         el = vecs[v].exp_len;
         if (el < 0) ref_orbit(vecs[v].exp_seed, el, ep);
         if (el == 0) ep = 0;
         else ref_orbit(vecs[v].exp_seed, ml, ep);
         check($sformatf("vec%0d_best_seed", v), best_seed, vecs[v].exp_seed);
         check($sformatf("vec%0d_best_len", v), best_len, 64'(el));
         check($sformatf("vec%0d_best_path", v), best_path, ep);
         check($sformatf("vec%0d_seeds_done", v), seeds_done, 64'(vecs[v].exp_sd));
         check($sformatf("vec%0d_starts", v), 64'(nst), 64'(vecs[v].exp_starts));
         if (vecs[v].cnt == 0) check("count_zero_latency", (cyc <= 2), 1);
      end

      // Seed 1 has length 0, so the sweep costs exactly the 4 minimum cycles.
      write_cfg(64'd1, 16'd1);
      go_and_wait(1'b0, cyc, nst);
      check("min_latency", 64'(cyc), 64'd4);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'hF; cfg_data = 8'h00;
      @(negedge clk);
      cfg_we = 1'b0;
      check("cfg_we_clears_done", done, 0);

      // go together with a write: the write wins, no sweep starts.
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'hA; go = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0; go = 1'b0;
      check("go_with_we_ignored", running, 0);

      // abort while idle has no effect on an accompanying go.
      write_cfg(64'd12, 16'd2);
      @(negedge clk);
      go = 1'b1; abort = 1'b1;
      @(negedge clk);
      go = 1'b0; abort = 1'b0;
      check("abort_idle_no_effect", running, 1);
      cyc = 0;
      while (!done && cyc < 5000) begin @(negedge clk); cyc++; end
      check("abort_idle_best_seed", best_seed, 12);

      // Abort right after the second UPDATE.
      write_cfg(64'd27, 16'd5);
      s0 = starts;
      @(negedge clk); go = 1'b1;
      @(negedge clk); go = 1'b0;
      cyc = 0;
      while (seeds_done != 16'd2 && cyc < 5000) begin @(negedge clk); cyc++; end
      check("abort_reach_second", seeds_done, 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_running", running, 0);
      check("abort_done", done, 0);
      check("abort_seeds_done", seeds_done, 2);
      check("abort_best_seed", best_seed, 27);
      check("abort_best_len", best_len, 111);
      repeat (3) @(negedge clk);
      check("abort_no_start", 64'(starts - s0), 2);
      check("abort_stays_idle", running, 0);

      // Reset in the middle of a sweep.
      write_cfg(64'd27, 16'd5);
      @(negedge clk); go = 1'b1;
      @(negedge clk); go = 1'b0;
      cyc = 0;
      while (seeds_done != 16'd1 && cyc < 5000) begin @(negedge clk); cyc++; end
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_running", running, 0);
      check("midrst_done", done, 0);
      check("midrst_core_start", core_start, 0);
      check("midrst_core_seed", core_seed, 0);
      check("midrst_best_len", best_len, 0);
      check("midrst_best_seed", best_seed, 0);
      check("midrst_best_path", best_path, 0);
      check("midrst_seeds_done", seeds_done, 0);
      go_and_wait(1'b0, cyc, nst);
      check("midrst_count_cleared", 64'(nst), 0);

      // Randomized sweeps, each repeated from DONE without rewriting the config.
      for (int r = 0; r < 12; r++) begin
         ms = 64'($urandom_range(0, 3000));
         ml = $urandom_range(1, 5);
         write_cfg(ms, 16'(ml));
         go_and_wait(1'($urandom_range(0, 1)), cyc, nst);
         begin
            logic [63:0] bs;
            int bl;
            model(ms, ml, bs, bl, mp, ns);
            check($sformatf("rnd%0d_best_seed", r), best_seed, bs);
            check($sformatf("rnd%0d_best_len", r), best_len, 64'(bl));
            check($sformatf("rnd%0d_best_path", r), best_path, mp);
            check($sformatf("rnd%0d_seeds_done", r), seeds_done, 64'(ml));
            check($sformatf("rnd%0d_starts", r), 64'(nst), 64'(ns));
            go_and_wait(1'b0, cyc, nst);
            check($sformatf("rnd%0d_rerun_seed", r), best_seed, bs);
            check($sformatf("rnd%0d_rerun_starts", r), 64'(nst), 64'(ns));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
